// File: rtl/mem_stage_controller.sv
// MEM-stage access sequencer: issues one req/ack access per EX/MEM instruction,
// lane-aligns store data, extracts/extends load data and stalls until complete.
module mem_stage_controller #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic [3:0]  memWrite,
  input  logic        memRead,
  input  logic [1:0]  memReadWidth,
  input  logic        memAck,
  input  logic [31:0] memRdata,
  output logic        memReq,
  output logic [31:0] memAddr,
  output logic [3:0]  memWe,
  output logic [31:0] memWdata,
  output logic        stall,
  output logic [31:0] readData,
  output logic        readValid,
  output logic        accessError
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      width_q;
  logic [1:0]      off_q;
  logic            load_q;

  logic        is_store;
  logic        pending;
  logic        word_acc;
  logic        half_acc;
  logic        bad_pat;
  logic        misaligned;
  logic        aligned;
  logic [31:0] shifted;
  logic [31:0] rd_ext;

  always_comb begin
    is_store   = (memWrite != '0);
    pending    = is_store | memRead;
    word_acc   = is_store ? (memWrite == 4'b1111) : (memReadWidth == 2'b00);
    half_acc   = is_store ? (memWrite == 4'b0011) : (memReadWidth == 2'b01);
    bad_pat    = is_store & ~((memWrite == 4'b1111) | (memWrite == 4'b0011) |
                              (memWrite == 4'b0001));
    misaligned = pending & (bad_pat | (word_acc & (address[1:0] != 2'b00)) |
                            (half_acc & address[0]));
    aligned    = pending & ~misaligned;
  end

  always_comb begin
    shifted = memRdata >> {off_q, 3'b000};
    unique case (width_q)
      2'b00:   rd_ext = shifted;
      2'b01:   rd_ext = {{16{shifted[15]}}, shifted[15:0]};
      2'b10:   rd_ext = {{24{shifted[7]}}, shifted[7:0]};
      default: rd_ext = {24'h000000, shifted[7:0]};
    endcase
  end

  // Gated by reset so the pipeline is never frozen while reset is held.
  assign stall = reset & (((state_q == IDLE) & aligned) | (state_q == ACCESS));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      width_q     <= '0;
      off_q       <= '0;
      load_q      <= 1'b0;
      memReq      <= 1'b0;
      memAddr     <= '0;
      memWe       <= '0;
      memWdata    <= '0;
      readData    <= '0;
      readValid   <= 1'b0;
      accessError <= 1'b0;
    end else begin
      readValid   <= 1'b0;
      accessError <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (misaligned) begin
            accessError <= 1'b1;
          end else if (aligned) begin
            memAddr  <= {address[31:2], 2'b00};
            memWe    <= is_store ? (memWrite << address[1:0]) : '0;
            memWdata <= writeData << {address[1:0], 3'b000};
            width_q  <= memReadWidth;
            off_q    <= address[1:0];
            load_q   <= ~is_store;
            memReq   <= 1'b1;
            cnt_q    <= '0;
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          if (memAck) begin
            memReq  <= 1'b0;
            memWe   <= '0;
            if (load_q) begin
              readData  <= rd_ext;
              readValid <= 1'b1;
            end
            state_q <= DONE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            memReq      <= 1'b0;
            memWe       <= '0;
            accessError <= 1'b1;
            readData    <= '0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_controller.sv
// Directed bench for mem_stage_controller: transaction-level expected cycle
// sequences plus literal pins, compared on every falling edge.
module tb_mem_stage_controller;
  localparam int TO = 16;
  localparam int NS = 8;
  localparam int S_REQ = 0, S_STALL = 1, S_ADDR = 2, S_WE = 3,
                 S_WDATA = 4, S_RDATA = 5, S_RVALID = 6, S_ERR = 7;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address, writeData, memRdata;
  logic [3:0]  memWrite;
  logic        memRead, memAck;
  logic [1:0]  memReadWidth;
  logic        memReq, stall, readValid, accessError;
  logic [31:0] memAddr, memWdata, readData;
  logic [3:0]  memWe;

  mem_stage_controller #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .address(address), .writeData(writeData),
    .memWrite(memWrite), .memRead(memRead), .memReadWidth(memReadWidth),
    .memAck(memAck), .memRdata(memRdata), .memReq(memReq), .memAddr(memAddr),
    .memWe(memWe), .memWdata(memWdata), .stall(stall), .readData(readData),
    .readValid(readValid), .accessError(accessError)
  );

  always #5 clock = ~clock;

  bit          care_m [NS];
  bit          care_p [NS];
  logic [31:0] exp_m  [NS];
  logic [31:0] exp_p  [NS];
  string       nm     [NS] = '{"memReq", "stall", "memAddr", "memWe",
                               "memWdata", "readData", "readValid", "accessError"};
  int n_checks = 0;
  int n_pass   = 0;

  bit win_open = 1'b0;
  bit win_chk  = 1'b0;
  int we_stall, we_req, we_err;
  int w_stall = 0, w_req = 0, w_err = 0;

  logic        pa_en = 1'b0, pw_en = 1'b0, pd_en = 1'b0, pr_en = 1'b0;
  logic [31:0] pa_v, pd_v, pr_v;
  logic [3:0]  pw_v;

  function automatic logic [31:0] act(int i);
    case (i)
      S_REQ:    return {31'b0, memReq};
      S_STALL:  return {31'b0, stall};
      S_ADDR:   return memAddr;
      S_WE:     return {28'b0, memWe};
      S_WDATA:  return memWdata;
      S_RDATA:  return readData;
      S_RVALID: return {31'b0, readValid};
      default:  return {31'b0, accessError};
    endcase
  endfunction

  always @(negedge clock) begin
    for (int i = 0; i < NS; i++) begin
      if (care_m[i]) begin
        n_checks++;
        if (act(i) === exp_m[i]) n_pass++;
        else $display("FAIL model %s: got %h want %h at %0t", nm[i], act(i), exp_m[i], $time);
      end
      if (care_p[i]) begin
        n_checks++;
        if (act(i) === exp_p[i]) n_pass++;
        else $display("FAIL pin %s: got %h want %h at %0t", nm[i], act(i), exp_p[i], $time);
      end
    end
    if (win_open) begin
      if (stall === 1'b1) w_stall++;
      if (memReq === 1'b1) w_req++;
      if (accessError === 1'b1) w_err++;
    end
    if (win_chk) begin
      if (we_stall >= 0) begin
        n_checks++;
        if (w_stall == we_stall) n_pass++;
        else $display("FAIL stall_cycles: got %0d want %0d", w_stall, we_stall);
      end
      if (we_req >= 0) begin
        n_checks++;
        if (w_req == we_req) n_pass++;
        else $display("FAIL req_cycles: got %0d want %0d", w_req, we_req);
      end
      if (we_err >= 0) begin
        n_checks++;
        if (w_err == we_err) n_pass++;
        else $display("FAIL err_pulses: got %0d want %0d", w_err, we_err);
      end
      w_stall = 0; w_req = 0; w_err = 0;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    for (int i = 0; i < NS; i++) begin
      care_m[i] = 1'b0;
      care_p[i] = 1'b0;
    end
    win_chk = 1'b0;
  endtask

  task automatic expm(int i, logic [31:0] v);
    care_m[i] = 1'b1; exp_m[i] = v;
  endtask

  task automatic expp(int i, logic [31:0] v);
    care_p[i] = 1'b1; exp_p[i] = v;
  endtask

  task automatic idle_in();
    address = '0; writeData = '0; memWrite = '0; memRead = 1'b0;
    memReadWidth = '0; memAck = 1'b0; memRdata = '0;
  endtask

  task automatic window(int s, int r, int e);
    win_open = 1'b0; we_stall = s; we_req = r; we_err = e; win_chk = 1'b1;
  endtask

  function automatic logic [31:0] ext(logic [31:0] d, logic [1:0] off, logic [1:0] w);
    logic [31:0] s;
    s = d >> (8 * off);
    case (w)
      2'b00:   return s;
      2'b01:   return {{16{s[15]}}, s[15:0]};
      2'b10:   return {{24{s[7]}}, s[7:0]};
      default: return {24'h0, s[7:0]};
    endcase
  endfunction

  // One EX/MEM instruction; ack_at < 0 means the memory never answers.
  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                     input logic rd, input logic [1:0] w, input int ack_at,
                     input logic [31:0] rdata, input logic stray);
    logic       st, is_word, is_half, mis, acked, is_load;
    logic [1:0] off;
    logic [7:0] we_sh;
    st      = (we != 4'b0);
    is_load = rd && !st;
    off     = a[1:0];
    is_word = st ? (we == 4'b1111) : (w == 2'b00);
    is_half = st ? (we == 4'b0011) : (w == 2'b01);
    mis = (st && we != 4'b1111 && we != 4'b0011 && we != 4'b0001) ||
          (is_word && off != 2'b00) || (is_half && off[0]);
    address = a; writeData = wd; memWrite = we; memRead = rd;
    memReadWidth = w; memRdata = rdata; memAck = stray;
    expm(S_REQ, 0); expm(S_RVALID, 0); expm(S_ERR, 0);
    if (mis) begin
      expm(S_STALL, 0);
      step(); idle_in();
      expm(S_ERR, 1); expm(S_STALL, 0); expm(S_REQ, 0); expm(S_RVALID, 0);
      step();
      expm(S_ERR, 0); expm(S_STALL, 0); expm(S_REQ, 0);
      return;
    end
    expm(S_STALL, 1);
    we_sh = {4'b0, we} << off;
    acked = 1'b0;
    for (int k = 0; k < TO; k++) begin
      step();
      memAck = (k == ack_at);
      expm(S_REQ, 1); expm(S_STALL, 1); expm(S_RVALID, 0); expm(S_ERR, 0);
      expm(S_ADDR, a & 32'hFFFF_FFFC);
      expm(S_WE, st ? {28'b0, we_sh[3:0]} : 32'b0);
      expm(S_WDATA, wd << (8 * off));
      if (pa_en) expp(S_ADDR, pa_v);
      if (pw_en) expp(S_WE, {28'b0, pw_v});
      if (pd_en) expp(S_WDATA, pd_v);
      if (k == ack_at) begin
        acked = 1'b1;
        break;
      end
    end
    step();
    memAck = stray;
    expm(S_REQ, 0); expm(S_STALL, 0); expm(S_WE, 0);
    expm(S_RVALID, {31'b0, is_load && acked});
    expm(S_ERR, {31'b0, !acked});
    if (!acked) expm(S_RDATA, 0);
    else if (is_load) expm(S_RDATA, ext(rdata, off, w));
    if (pr_en) expp(S_RDATA, pr_v);
    step(); idle_in();
    pa_en = 0; pw_en = 0; pd_en = 0; pr_en = 0;
  endtask

  initial begin
    reset = 1'b0;
    idle_in();
    address = 32'h100; memRead = 1'b1;
    for (int i = 0; i < NS; i++) expm(i, 0);
    step();
    reset = 1'b1; idle_in();
    expm(S_REQ, 0); expm(S_STALL, 0);
    step();

    win_open = 1'b1;
    pa_en = 1; pa_v = 32'h100; pr_en = 1; pr_v = 32'h8899AABB;
    txn(32'h100, 0, 4'b0000, 1, 2'b00, 1, 32'h8899AABB, 0);
    window(3, 2, 0);

    pa_en = 1; pa_v = 32'h200; pw_en = 1; pw_v = 4'b1000; pd_en = 1; pd_v = 32'hA500_0000;
    txn(32'h203, 32'h0000_00A5, 4'b0001, 0, 2'b00, 0, 32'h0, 0);
    pw_en = 1; pw_v = 4'b1100; pd_en = 1; pd_v = 32'h1234_0000;
    txn(32'h202, 32'h0000_1234, 4'b0011, 1, 2'b00, 2, 32'h0, 0);
    pr_en = 1; pr_v = 32'hFFFF_FF80;
    txn(32'h403, 0, 4'b0000, 1, 2'b10, 0, 32'h80FF_7F01, 1);
    pr_en = 1; pr_v = 32'h0000_0080;
    txn(32'h403, 0, 4'b0000, 1, 2'b11, 3, 32'h80FF_7F01, 0);
    pr_en = 1; pr_v = 32'hFFFF_80FF;
    txn(32'h402, 0, 4'b0000, 1, 2'b01, 0, 32'h80FF_7F01, 0);
    txn(32'h104, 32'hCAFE_F00D, 4'b1111, 0, 2'b00, 1, 32'h0, 0);
    txn(32'h401, 0, 4'b0000, 1, 2'b11, 0, 32'h1234_5678, 0);

    win_open = 1'b1;
    txn(32'h101, 0, 4'b0000, 1, 2'b00, 0, 32'h0, 0);
    window(0, 0, 1);
    win_open = 1'b1;
    txn(32'h200, 32'hFFFF_FFFF, 4'b0101, 0, 2'b00, 0, 32'h0, 0);
    window(0, 0, 1);
    txn(32'h203, 0, 4'b0000, 1, 2'b01, 0, 32'h0, 0);

    win_open = 1'b1;
    txn(32'h500, 0, 4'b0000, 1, 2'b00, -1, 32'h5555_5555, 0);
    window(TO + 1, TO, 1);

    address = 32'h300; memRead = 1'b1; memReadWidth = 2'b00;
    expm(S_STALL, 1);
    step();
    expm(S_REQ, 1);
    step();
    reset = 1'b0;
    #1;
    for (int i = 0; i < NS; i++) expm(i, 0);
    step();
    for (int i = 0; i < NS; i++) expp(i, 0);
    step();
    reset = 1'b1; idle_in();
    expm(S_REQ, 0); expm(S_STALL, 0);
    step();

    win_open = 1'b1;
    pa_en = 1; pa_v = 32'h600; pr_en = 1; pr_v = 32'hDEAD_BEEF;
    txn(32'h600, 0, 4'b0000, 1, 2'b00, 0, 32'hDEAD_BEEF, 0);
    window(2, 1, 0);
    expm(S_STALL, 0); expm(S_REQ, 0); expm(S_RVALID, 0);
    step();
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_stage_controller.md
# mem_stage_controller

Sequences data-memory accesses for the instruction held in the EX/MEM pipeline register. It drives a single-port, variable-latency data memory through a req/ack handshake and aligns write data into byte lanes. It extracts and extends read data, and stalls the pipeline until each access completes. It sits between the EX/MEM register outputs and the data memory, feeding MEM/WB.

## Interface
- TIMEOUT, 16: maximum number of ACCESS cycles to wait for memAck before aborting.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- address  in  32  byte address (EX/MEM ALU result).
- writeData  in  32  store data, right-justified (byte/half in low bits).
- memWrite  in  4  store byte enables, lane-0 relative: 4'b0001 byte, 4'b0011 half, 4'b1111 word, 0 = no store.
- memRead  in  1  load request (EX/MEM memToReg).
- memReadWidth  in  2  00 word, 01 half signed, 10 byte signed, 11 byte unsigned.
- memAck  in  1  memory completion; sampled only in ACCESS.
- memRdata  in  32  memory read word, valid with memAck.
- memReq  out  1  memory request, held until ack or timeout.
- memAddr  out  32  word address: {address[31:2],2'b00}.
- memWe  out  4  lane-shifted byte enables (0 for loads).
- memWdata  out  32  lane-shifted store data.
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational).
- readData  out  32  aligned, extended load result.
- readValid  out  1  one-cycle pulse: readData valid.
- accessError  out  1  one-cycle pulse: misaligned access or timeout.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: an access is pending if memWrite≠0 or memRead=1. If memWrite≠0, the access is a store and memRead is ignored.
- Misalignment rules:
  - Word (memWrite 4'b1111 or width 00) with address[1:0]≠0 is misaligned.
  - Half (memWrite 4'b0011 or width 01) with address[0]=1 is misaligned.
  - Any other memWrite pattern is an error.
- Misaligned access in IDLE: no request, no stall, accessError pulses the next cycle, FSM stays IDLE.
- Aligned access in IDLE: stall=1 combinationally. On the next edge, register memAddr, memWe=memWrite<<address[1:0], memWdata=writeData<<(8*address[1:0]), latch the width and offset, set memReq=1, go to ACCESS, clear the timeout counter.
- ACCESS: stall=1, memReq=1, counter increments each cycle.
  - memAck=1: next edge clears memReq/memWe. For a load, it also registers readData and sets readValid=1. Go to DONE.
  - Counter reaches TIMEOUT-1 without ack: next edge clears memReq, pulses accessError, sets readData=0 and readValid=0, and goes to DONE.
- DONE: stall=0, so the pipeline advances at the end of this cycle and MEM/WB captures readData. The FSM goes to IDLE unconditionally, so the same instruction is never re-issued.
- Read extraction: s = memRdata >> (8*offset).
  - Width 00: readData = s.
  - Width 01: readData = sign-extended s[15:0].
  - Width 10: readData = sign-extended s[7:0].
  - Width 11: readData = zero-extended s[7:0].
- memAck outside ACCESS is ignored.

## Timing
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - memReq, memWe, memAddr, memWdata, readData, readValid, accessError and the counter all go to 0.
  - stall reads 0 while reset is held.
  - Reset mid-ACCESS drops memReq immediately; the access is abandoned.
- Minimum access: detect cycle (IDLE, stall=1), one ACCESS cycle with ack, then DONE. That is 2 stall cycles; readValid is high in DONE.
- Each extra wait cycle before memAck adds one stall cycle.
- Timeout: memReq is high for exactly TIMEOUT cycles. accessError is high in the DONE cycle.
- Back-to-back accesses: a new request is evaluated in the IDLE cycle after DONE. The minimum spacing is 3 cycles per access.
- readValid and the timeout accessError are high only in DONE. The misalignment accessError is high in the cycle after detection.

## Test plan
- Word load at address 0x100, memAck one cycle after memReq, memRdata=0x8899AABB:
  - Required: memAddr=0x100, stall high for 3 cycles.
  - Required: readValid pulse with readData=0x8899AABB.
- Byte stores:
  - writeData=0x000000A5, memWrite=4'b0001, address 0x203: memWe=4'b1000, memWdata=0xA5000000, memAddr=0x200.
  - Half store at address 0x202, writeData=0x1234: memWe=4'b1100, memWdata=0x12340000.
- Loads from memRdata=0x80FF7F01:
  - Width 10 at offset 3: readData=0xFFFFFF80.
  - Width 11 at offset 3: readData=0x00000080.
  - Width 01 at offset 2: readData=0xFFFF80FF.
- Misaligned accesses:
  - Word load at 0x101: no memReq, stall stays 0, single accessError pulse.
  - Store with memWrite=4'b0101: same response.
- Timeout: no memAck. Required: memReq high exactly 16 cycles, then accessError and readValid=0 in DONE, then IDLE.
- Reset asserted during ACCESS (the cycle after memReq rises): memReq, stall and all outputs drop to 0 asynchronously. After release, a new word load completes normally.
